// File: rtl/hdmi_island_pkg.sv
// Shared encodings and period lengths for the HDMI data island scheduler.
package hdmi_island_pkg;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam int CTRL_GAP_MIN = 12;
    localparam int HEADER_W     = 24;
    localparam int SUB_W        = 224;

    typedef enum logic [1:0] {
        MODE_CTRL     = 2'd0,
        MODE_PREAMBLE = 2'd1,
        MODE_GUARD    = 2'd2,
        MODE_DATA     = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LGUARD,
        ST_DATA,
        ST_TGUARD
    } state_t;

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational arbiter: source 0 has strict priority, sources 1..N_SRC-1
// share round-robin order starting at ptr.
module rr_priority_arbiter #(
    parameter int N_SRC = 4,
    parameter int PW    = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_SRC-1:0] winner,
    output logic             any,
    output logic [PW-1:0]    next_ptr
);

    logic [N_SRC-1:0]          hi_req;
    logic [N_SRC-1:0]          lo_req;
    logic [N_SRC-1:0]          hi_pick;
    logic [N_SRC-1:0]          lo_pick;
    logic [N_SRC-1:0]          rr_win;
    logic [PW-1:0][N_SRC-1:0]  nxt_col;
    logic [PW-1:0]             rr_next;

    // Requesters at or above ptr come first, the rest wrap around behind them.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            localparam logic [PW-1:0] NXT = (gi == N_SRC - 1) ? PW'(1) : PW'(gi + 1);
            if (gi == 0) begin : g_prio
                assign hi_req[gi] = 1'b0;
                assign lo_req[gi] = 1'b0;
            end else begin : g_rr
                assign hi_req[gi] = req[gi] && (PW'(gi) >= ptr);
                assign lo_req[gi] = req[gi] && (PW'(gi) <  ptr);
            end
            for (genvar gj = 0; gj < PW; gj++) begin : g_nxt
                assign nxt_col[gj][gi] = NXT[gj];
            end
        end
        for (genvar gj = 0; gj < PW; gj++) begin : g_ptr
            assign rr_next[gj] = |(nxt_col[gj] & rr_win);
        end
    endgenerate

    assign hi_pick  = hi_req & (~hi_req + N_SRC'(1));
    assign lo_pick  = lo_req & (~lo_req + N_SRC'(1));
    assign rr_win   = (|hi_req) ? hi_pick : lo_pick;
    assign any      = |req;
    assign winner   = req[0] ? N_SRC'(1) : rr_win;
    assign next_ptr = (!req[0] && (|rr_win)) ? rr_next : ptr;

endmodule

// File: rtl/data_island_scheduler.sv
// Sequences HDMI data islands in blanking and picks the source for each
// 32-pixel packet slot; latches that source's header/subpackets.
module data_island_scheduler
    import hdmi_island_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int MAX_PACKETS = 18
) (
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    input  logic                   island_allow,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*24-1:0]    header_in,
    input  logic [N_SRC*224-1:0]   sub_in,
    output logic [N_SRC-1:0]       grant,
    output logic [1:0]             mode,
    output logic [23:0]            header,
    output logic [223:0]           sub,
    output logic [4:0]             packet_cnt
);

    localparam int PW    = (N_SRC > 2) ? $clog2(N_SRC) : 1;
    localparam int PKT_W = $clog2(MAX_PACKETS + 1);
    localparam int PAY_W = HEADER_W + SUB_W;

    state_t                     state_reg;
    mode_t                      mode_reg;
    logic [2:0]                 timer_reg;
    logic [4:0]                 packet_cnt_reg;
    logic [3:0]                 gap_cnt_reg;
    logic [PKT_W-1:0]           pkt_in_island_reg;
    logic [PW-1:0]              rr_ptr_reg;
    logic [HEADER_W-1:0]        header_reg;
    logic [SUB_W-1:0]           sub_reg;

    logic [N_SRC-1:0]           winner;
    logic                       any_req;
    logic [PW-1:0]              next_ptr;
    logic [PAY_W-1:0][N_SRC-1:0] pay_col;
    logic [PAY_W-1:0]           sel_pay;
    logic                       at_lguard_end;
    logic                       at_pkt_end;
    logic                       cont_island;
    logic                       load;

    rr_priority_arbiter #(
        .N_SRC (N_SRC),
        .PW    (PW)
    ) u_arb (
        .req      (req),
        .ptr      (rr_ptr_reg),
        .winner   (winner),
        .any      (any_req),
        .next_ptr (next_ptr)
    );

    // One-hot AND-OR mux of {header, sub}; a zero winner yields the null packet.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pay_src
            for (genvar gj = 0; gj < HEADER_W; gj++) begin : g_hdr
                assign pay_col[SUB_W + gj][gi] = header_in[gi*HEADER_W + gj];
            end
            for (genvar gj = 0; gj < SUB_W; gj++) begin : g_sub
                assign pay_col[gj][gi] = sub_in[gi*SUB_W + gj];
            end
        end
        for (genvar gi = 0; gi < PAY_W; gi++) begin : g_pay_bit
            assign sel_pay[gi] = |(pay_col[gi] & winner);
        end
    endgenerate

    assign at_lguard_end = (state_reg == ST_LGUARD) && (timer_reg == 3'(GUARD_LEN - 1));
    assign at_pkt_end    = (state_reg == ST_DATA) && (packet_cnt_reg == 5'(PACKET_LEN - 1));
    assign cont_island   = at_pkt_end && island_allow && any_req &&
                           (pkt_in_island_reg < PKT_W'(MAX_PACKETS));
    assign load          = at_lguard_end || cont_island;

    assign grant      = (load && reset_n) ? winner : '0;
    assign mode       = mode_reg;
    assign header     = header_reg;
    assign sub        = sub_reg;
    assign packet_cnt = packet_cnt_reg;

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            mode_reg          <= MODE_CTRL;
            timer_reg         <= '0;
            packet_cnt_reg    <= '0;
            gap_cnt_reg       <= 4'(CTRL_GAP_MIN);
            pkt_in_island_reg <= '0;
            rr_ptr_reg        <= PW'(1);
            header_reg        <= '0;
            sub_reg           <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    pkt_in_island_reg <= '0;
                    if (gap_cnt_reg < 4'(CTRL_GAP_MIN))
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    if (gap_cnt_reg == 4'(CTRL_GAP_MIN) && island_allow && any_req) begin
                        state_reg <= ST_PREAMBLE;
                        mode_reg  <= MODE_PREAMBLE;
                        timer_reg <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (timer_reg == 3'(PREAMBLE_LEN - 1)) begin
                        state_reg <= ST_LGUARD;
                        mode_reg  <= MODE_GUARD;
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 3'd1;
                    end
                end
                ST_LGUARD: begin
                    if (at_lguard_end) begin
                        state_reg      <= ST_DATA;
                        mode_reg       <= MODE_DATA;
                        timer_reg      <= '0;
                        packet_cnt_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (at_pkt_end) begin
                        packet_cnt_reg <= '0;
                        if (!cont_island) begin
                            state_reg <= ST_TGUARD;
                            mode_reg  <= MODE_GUARD;
                            timer_reg <= '0;
                        end
                    end else begin
                        packet_cnt_reg <= packet_cnt_reg + 5'd1;
                    end
                end
                ST_TGUARD: begin
                    if (timer_reg == 3'(GUARD_LEN - 1)) begin
                        state_reg   <= ST_IDLE;
                        mode_reg    <= MODE_CTRL;
                        timer_reg   <= '0;
                        gap_cnt_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 3'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    mode_reg  <= MODE_CTRL;
                end
            endcase

            if (load) begin
                header_reg        <= sel_pay[PAY_W-1:SUB_W];
                sub_reg           <= sel_pay[SUB_W-1:0];
                pkt_in_island_reg <= pkt_in_island_reg + PKT_W'(1);
                rr_ptr_reg        <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Self-checking bench for data_island_scheduler: per-cycle mode/grant checks
// plus a scoreboard of expected packet payloads.
module tb_data_island_scheduler;

    logic           clk_pixel = 1'b0;
    logic           reset_n;
    logic           island_allow;
    logic [3:0]     req;
    logic [95:0]    header_in;
    logic [895:0]   sub_in;
    logic [3:0]     grant;
    logic [1:0]     mode;
    logic [23:0]    header;
    logic [223:0]   sub;
    logic [4:0]     packet_cnt;

    int checks = 0;
    int errors = 0;
    int pkt_seen = 0;

    typedef struct {
        logic [23:0]  h;
        logic [223:0] s;
    } sb_t;

    typedef struct {
        logic [3:0] req;
        logic       allow;
        int         n;
        logic [1:0] mode;
        logic [3:0] grant;
    } vec_t;

    sb_t          sb[$];
    logic [23:0]  hdr_tab [4];
    logic [223:0] sub_tab [4];
    logic [4:0]   exp_cnt;
    vec_t         tab [7];

    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

    always #5 clk_pixel = ~clk_pixel;

    data_island_scheduler #(.N_SRC(4), .MAX_PACKETS(18)) dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .island_allow (island_allow),
        .req          (req),
        .header_in    (header_in),
        .sub_in       (sub_in),
        .grant        (grant),
        .mode         (mode),
        .header       (header),
        .sub          (sub),
        .packet_cnt   (packet_cnt)
    );

    function automatic int oh_idx(input logic [3:0] v);
        int r = 0;
        for (int k = 0; k < 4; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic cycle(input logic [3:0] r, input logic al, input logic [1:0] em,
                         input logic [3:0] eg, input bit enull, input string nm);
        sb_t e;
        req = r;
        island_allow = al;
        @(negedge clk_pixel);
        checks++;
        if (mode !== em) begin
            errors++;
            $display("FAIL %s mode got %0d want %0d t=%0t", nm, mode, em, $time);
        end
        checks++;
        if (grant !== eg) begin
            errors++;
            $display("FAIL %s grant got %b want %b t=%0t", nm, grant, eg, $time);
        end
        if (em == 2'd3) begin
            checks++;
            if (packet_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL %s packet_cnt got %0d want %0d t=%0t", nm, packet_cnt, exp_cnt, $time);
            end
        end
        if (mode === 2'd3 && packet_cnt === 5'd0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s sb_empty got packet header=%h want none t=%0t", nm, header, $time);
            end else begin
                e = sb.pop_front();
                pkt_seen++;
                if (header !== e.h || sub !== e.s) begin
                    errors++;
                    $display("FAIL %s payload got hdr=%h sub=%h want hdr=%h sub=%h", nm, header, sub, e.h, e.s);
                end else begin
                    $display("packet %0d header=%h sub[31:0]=%h", pkt_seen, header, sub[31:0]);
                end
            end
        end
        if (eg != 4'b0) begin
            e.h = hdr_tab[oh_idx(eg)];
            e.s = sub_tab[oh_idx(eg)];
            sb.push_back(e);
        end else if (enull) begin
            e.h = '0;
            e.s = '0;
            sb.push_back(e);
        end
        exp_cnt = (em == 2'd3) ? exp_cnt + 5'd1 : 5'd0;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic check_clear(input string nm);
        checks++;
        if (mode !== 2'd0 || grant !== 4'b0 || header !== 24'h0 || sub !== 224'h0 || packet_cnt !== 5'd0) begin
            errors++;
            $display("FAIL %s got mode=%0d grant=%b hdr=%h cnt=%0d sub_nz=%0d want all zero",
                     nm, mode, grant, header, packet_cnt, |sub);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        island_allow = 1'b0;
        @(negedge clk_pixel);
        @(posedge clk_pixel);
        #1;
        @(negedge clk_pixel);
        check_clear("reset_state");
        sb.delete();
        exp_cnt = '0;
        reset_n = 1'b1;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic prefix(input logic [3:0] r_start, input logic [3:0] r_rest,
                          input logic [3:0] eg, input bit enull, input bit with_start);
        if (with_start) cycle(r_start, 1'b1, 2'd0, 4'b0, 1'b0, "start");
        repeat (8) cycle(r_rest, 1'b1, 2'd1, 4'b0, 1'b0, "preamble");
        cycle(r_rest, 1'b1, 2'd2, 4'b0, 1'b0, "lguard0");
        cycle(r_rest, 1'b1, 2'd2, eg, enull, "lguard_load");
    endtask

    task automatic packet(input logic [3:0] r, input logic [31:0] al, input logic [3:0] eg);
        for (int i = 0; i < 31; i++) cycle(r, al[i], 2'd3, 4'b0, 1'b0, "data");
        cycle(r, al[31], 2'd3, eg, 1'b0, "pkt_end");
    endtask

    task automatic trailer(input logic [3:0] r, input logic al);
        repeat (2) cycle(r, al, 2'd2, 4'b0, 1'b0, "tguard");
        cycle(r, al, 2'd0, 4'b0, 1'b0, "ctrl_after");
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            hdr_tab[s] = 24'h8A_0000 + 24'(s * 24'h010203);
            sub_tab[s] = {7{32'hC0DE_0000 + 32'(s * 32'h0101)}};
        end
        hdr_tab[0] = 24'h02_0000;
        for (int s = 0; s < 4; s++) begin
            header_in[s*24 +: 24] = hdr_tab[s];
            sub_in[s*224 +: 224]  = sub_tab[s];
        end
        exp_cnt = '0;

        // Basic island: single audio-sample packet.
        tab[0] = '{req: 4'b0001, allow: 1'b1, n: 1,  mode: 2'd0, grant: 4'b0000};
        tab[1] = '{req: 4'b0001, allow: 1'b1, n: 8,  mode: 2'd1, grant: 4'b0000};
        tab[2] = '{req: 4'b0001, allow: 1'b1, n: 1,  mode: 2'd2, grant: 4'b0000};
        tab[3] = '{req: 4'b0001, allow: 1'b1, n: 1,  mode: 2'd2, grant: 4'b0001};
        tab[4] = '{req: 4'b0000, allow: 1'b1, n: 32, mode: 2'd3, grant: 4'b0000};
        tab[5] = '{req: 4'b0000, allow: 1'b1, n: 2,  mode: 2'd2, grant: 4'b0000};
        tab[6] = '{req: 4'b0000, allow: 1'b1, n: 3,  mode: 2'd0, grant: 4'b0000};

        do_reset();
        for (int i = 0; i < 7; i++)
            for (int k = 0; k < tab[i].n; k++)
                cycle(tab[i].req, tab[i].allow, tab[i].mode, tab[i].grant, 1'b0, "t1_table");

        // Round-robin over 1..3, then priority source 0 wins.
        do_reset();
        prefix(4'b1110, 4'b1110, 4'b0010, 1'b0, 1'b1);
        packet(4'b1110, ALL1, 4'b0100);
        packet(4'b1110, ALL1, 4'b1000);
        packet(4'b1111, ALL1, 4'b0001);
        packet(4'b0000, ALL1, 4'b0000);
        trailer(4'b0000, 1'b1);

        // Packet limit and minimum control gap.
        do_reset();
        prefix(4'b1111, 4'b1111, 4'b0001, 1'b0, 1'b1);
        repeat (17) packet(4'b1111, ALL1, 4'b0001);
        packet(4'b1111, ALL1, 4'b0000);
        repeat (2) cycle(4'b1111, 1'b1, 2'd2, 4'b0, 1'b0, "t3_tguard");
        repeat (13) cycle(4'b1111, 1'b1, 2'd0, 4'b0, 1'b0, "t3_gap");
        cycle(4'b1111, 1'b1, 2'd1, 4'b0, 1'b0, "t3_restart");

        // allow drops mid-packet: packet completes, no further grant.
        do_reset();
        prefix(4'b0110, 4'b0110, 4'b0010, 1'b0, 1'b1);
        packet(4'b0110, 32'h0000_03FF, 4'b0000);
        trailer(4'b0110, 1'b0);
        repeat (4) cycle(4'b0110, 1'b0, 2'd0, 4'b0, 1'b0, "t4_idle");

        // Request withdrawn during preamble: null packet.
        do_reset();
        prefix(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
        packet(4'b0000, ALL1, 4'b0000);
        trailer(4'b0000, 1'b1);

        // Reset in mid-packet, then immediate restart.
        do_reset();
        prefix(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cycle(4'b0000, 1'b1, 2'd3, 4'b0, 1'b0, "t6_data");
        reset_n = 1'b0;
        cycle(4'b0000, 1'b1, 2'd3, 4'b0, 1'b0, "t6_rst_cnt15");
        reset_n = 1'b1;
        sb.delete();
        exp_cnt = '0;
        req = 4'b0001;
        island_allow = 1'b1;
        @(negedge clk_pixel);
        check_clear("t6_after_reset");
        @(posedge clk_pixel);
        #1;
        prefix(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
        packet(4'b0000, ALL1, 4'b0000);
        trailer(4'b0000, 1'b1);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
